// File: rtl/cache_table_nway.sv
// N-way set-associative tag/data table with post-reset valid/dirty sweep,
// registered write-first lookup port, tag compare and per-set replacement pointer.
module cache_table_nway #(
  parameter int unsigned WAYS    = 2,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned TAG_W   = 20,
  parameter int unsigned LINE_W  = 128,
  localparam int unsigned OFFSET_W = $clog2(LINE_W / 8),
  localparam int unsigned ENTRY_W  = TAG_W + 2 + LINE_W,
  localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready_o,
  input  logic                     rd_req_i,
  input  logic [INDEX_W-1:0]       r_index_i,
  input  logic [TAG_W-1:0]         cmp_tag_i,
  output logic [WAYS*ENTRY_W-1:0]  r_data_o,
  output logic                     hit_o,
  output logic [WAY_W-1:0]         hit_way_o,
  output logic [WAY_W-1:0]         victim_way_o,
  input  logic [1:0]               w_type_i,
  input  logic [WAY_W-1:0]         way_i,
  input  logic [INDEX_W-1:0]       w_index_i,
  input  logic [OFFSET_W-1:0]      offset_i,
  input  logic [3:0]               wstrb_i,
  input  logic [ENTRY_W-1:0]       w_data_i
);
  localparam int unsigned SETS  = 2 ** INDEX_W;
  localparam int unsigned D_BIT = LINE_W;
  localparam int unsigned V_BIT = LINE_W + 1;
  localparam int unsigned T_LSB = LINE_W + 2;

  typedef enum logic {StInit, StRun} state_e;

  state_e                  state_q, state_d;
  logic [INDEX_W-1:0]      cnt_q, cnt_d;
  logic [ENTRY_W-1:0]      mem [SETS][WAYS];
  logic [WAY_W-1:0]        repl_q [SETS];
  logic                    ready, rd_en, wr_en, wr_full;
  logic [ENTRY_W-1:0]      old_e, new_e;
  logic [WAYS*ENTRY_W-1:0] rd_fwd, r_data_q;
  logic [WAY_W-1:0]        ptr_fwd, victim, victim_q, hit_way;
  logic                    hit;
  logic [OFFSET_W-3:0]     word_idx;
  logic                    unused_offset;

  assign unused_offset = ^offset_i[1:0];
  assign word_idx      = offset_i[OFFSET_W-1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = StRun;
      end
      StRun:   cnt_d = cnt_q;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready   = (state_q == StRun);
  assign rd_en   = ready & rd_req_i;
  assign wr_full = ready & (w_type_i == 2'b10);
  assign wr_en   = wr_full | (ready & (w_type_i == 2'b01));

  // Partial write merges strobed bytes into the stored word and marks the line dirty
  always_comb begin
    old_e = mem[w_index_i][way_i];
    new_e = w_data_i;
    if (w_type_i == 2'b01) begin
      new_e = old_e;
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) new_e[int'(word_idx) * 32 + b * 8 +: 8] = w_data_i[b * 8 +: 8];
      end
      new_e[D_BIT] = 1'b1;
    end
  end

  // Sweep zeroes the whole entry; only v/d matter
  always_ff @(posedge clk) begin
    if (!ready) begin
      for (int k = 0; k < WAYS; k++) mem[cnt_q][k] <= '0;
    end else if (wr_en) begin
      mem[w_index_i][way_i] <= new_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) repl_q[s] <= '0;
    end else if (wr_full) begin
      repl_q[w_index_i] <= way_i + 1'b1;
    end
  end

  // Write-first view of the looked-up set, including pointer update
  always_comb begin
    rd_fwd  = '0;
    ptr_fwd = repl_q[r_index_i];
    if (wr_full && (w_index_i == r_index_i)) ptr_fwd = way_i + 1'b1;
    for (int k = 0; k < WAYS; k++) begin
      rd_fwd[k * ENTRY_W +: ENTRY_W] = mem[r_index_i][k];
      if (wr_en && (w_index_i == r_index_i) && (way_i == WAY_W'(k))) begin
        rd_fwd[k * ENTRY_W +: ENTRY_W] = new_e;
      end
    end
    victim = ptr_fwd;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (!rd_fwd[k * ENTRY_W + V_BIT]) victim = WAY_W'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_q <= '0;
      victim_q <= '0;
    end else if (rd_en) begin
      r_data_q <= rd_fwd;
      victim_q <= victim;
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (r_data_q[k * ENTRY_W + V_BIT] &&
          (r_data_q[k * ENTRY_W + T_LSB +: TAG_W] == cmp_tag_i)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(k);
      end
    end
  end

  assign ready_o      = ready;
  assign r_data_o     = r_data_q;
  assign hit_o        = hit;
  assign hit_way_o    = hit_way;
  assign victim_way_o = victim_q;

endmodule

// File: tb/tb_cache_table_nway.sv
// Bench for cache_table_nway (4 ways, 256 sets): directed scenarios plus random
// traffic compared against a per-field array model of the table.
module tb_cache_table_nway;
  localparam int unsigned WAYS = 4, INDEX_W = 8, TAG_W = 20, LINE_W = 128;
  localparam int unsigned SETS = 256, ENTRY_W = 150, WAY_W = 2, OFFSET_W = 4;
  localparam int unsigned RW = WAYS * ENTRY_W;

  logic clk = 1'b0, rst = 1'b1;
  logic ready_o, rd_req_i = 1'b0, hit_o;
  logic [INDEX_W-1:0] r_index_i = '0, w_index_i = '0;
  logic [TAG_W-1:0] cmp_tag_i = '0;
  logic [RW-1:0] r_data_o;
  logic [WAY_W-1:0] hit_way_o, victim_way_o, way_i = '0;
  logic [1:0] w_type_i = 2'b00;
  logic [OFFSET_W-1:0] offset_i = '0;
  logic [3:0] wstrb_i = '0;
  logic [ENTRY_W-1:0] w_data_i = '0;

  always #5 clk = ~clk;

  cache_table_nway #(.WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .ready_o(ready_o), .rd_req_i(rd_req_i), .r_index_i(r_index_i),
    .cmp_tag_i(cmp_tag_i), .r_data_o(r_data_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
    .victim_way_o(victim_way_o), .w_type_i(w_type_i), .way_i(way_i), .w_index_i(w_index_i),
    .offset_i(offset_i), .wstrb_i(wstrb_i), .w_data_i(w_data_i)
  );

  int n_checks = 0, n_fail = 0;

  logic [TAG_W-1:0]  m_tag  [SETS][WAYS];
  logic [LINE_W-1:0] m_data [SETS][WAYS];
  bit m_v [SETS][WAYS];
  bit m_d [SETS][WAYS];
  bit m_known [SETS][WAYS];
  int m_ptr [SETS];
  bit m_ready;
  int m_cnt;
  logic [RW-1:0] exp_rd, exp_mask;
  int exp_vic;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int k = 0; k < WAYS; k++) begin
        m_v[s][k] = 0; m_d[s][k] = 0; m_known[s][k] = 0;
        m_tag[s][k] = '0; m_data[s][k] = '0;
      end
    end
    m_ready = 0; m_cnt = 0;
    exp_rd = '0; exp_mask = '1; exp_vic = 0;
  endtask

  task automatic model_write(input int wt, input int wy, input int widx, input int off,
                             input logic [3:0] strb, input logic [ENTRY_W-1:0] wd);
    if (wt == 2) begin
      m_tag[widx][wy]  = wd[ENTRY_W-1 -: TAG_W];
      m_v[widx][wy]    = wd[LINE_W+1];
      m_d[widx][wy]    = wd[LINE_W];
      m_data[widx][wy] = wd[LINE_W-1:0];
      m_known[widx][wy] = 1;
      m_ptr[widx] = (wy + 1) % WAYS;
    end else if (wt == 1) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_data[widx][wy][(off / 4) * 32 + b * 8 +: 8] = wd[b * 8 +: 8];
      m_d[widx][wy] = 1;
    end
  endtask

  task automatic model_lookup(input int idx);
    exp_vic = -1;
    for (int k = 0; k < WAYS; k++) begin
      if (m_known[idx][k]) begin
        exp_rd[k * ENTRY_W +: ENTRY_W] = {m_tag[idx][k], m_v[idx][k], m_d[idx][k], m_data[idx][k]};
        exp_mask[k * ENTRY_W +: ENTRY_W] = '1;
      end else begin
        exp_rd[k * ENTRY_W +: ENTRY_W] = {{TAG_W{1'b0}}, m_v[idx][k], m_d[idx][k], {LINE_W{1'b0}}};
        exp_mask[k * ENTRY_W +: ENTRY_W] = {{TAG_W{1'b0}}, 2'b11, {LINE_W{1'b0}}};
      end
      if (exp_vic < 0 && !m_v[idx][k]) exp_vic = k;
    end
    if (exp_vic < 0) exp_vic = m_ptr[idx];
  endtask

  // One clock: drive a request, advance, update model, compare registered outputs
  task automatic cyc(input bit rd, input int ridx, input int wt, input int wy, input int widx,
                     input int off, input logic [3:0] strb, input logic [ENTRY_W-1:0] wd);
    bit was_ready;
    rd_req_i = rd; r_index_i = INDEX_W'(ridx);
    w_type_i = 2'(wt); way_i = WAY_W'(wy); w_index_i = INDEX_W'(widx);
    offset_i = OFFSET_W'(off); wstrb_i = strb; w_data_i = wd;
    @(posedge clk); #1;
    rd_req_i = 1'b0; w_type_i = 2'b00;
    was_ready = m_ready;
    if (!m_ready) begin
      m_cnt++;
      if (m_cnt == SETS) m_ready = 1;
    end
    if (was_ready) begin
      model_write(wt, wy, widx, off, strb, wd);
      if (rd) model_lookup(ridx);
    end
    chk("ready", ready_o, m_ready);
    chk("rdata", r_data_o & exp_mask, exp_rd & exp_mask);
    chk("victim", victim_way_o, exp_vic);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 4'h0, '0);
  endtask

  task automatic hit_chk(input logic [TAG_W-1:0] tag);
    bit eh = 0;
    int ew = 0;
    cmp_tag_i = tag;
    #1;
    for (int k = 0; k < WAYS; k++) begin
      if (!eh && exp_rd[k * ENTRY_W + LINE_W + 1] &&
          exp_rd[k * ENTRY_W + LINE_W + 2 +: TAG_W] == tag) begin
        eh = 1; ew = k;
      end
    end
    chk("hit", hit_o, eh);
    chk("hit_way", hit_way_o, ew);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ready"}, ready_o, 0);
    chk({tag, "_rdata"}, r_data_o, 0);
    chk({tag, "_hit"}, hit_o, 0);
    chk({tag, "_hit_way"}, hit_way_o, 0);
    chk({tag, "_victim"}, victim_way_o, 0);
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input logic [TAG_W-1:0] t, input bit v, input bit d,
                                             input logic [LINE_W-1:0] data);
    return {t, v, d, data};
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [LINE_W-1:0] line;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp_tag_i = '0;
    rst_chk("reset");
    rst = 1'b0;
    repeat (SETS) idle();

    cyc(1, 77, 0, 0, 0, 0, 4'h0, '0);
    hit_chk(TAG_W'(0));
    chk("init_victim", victim_way_o, 0);

    line = {32'hA5A5A5A5, 32'h11223344, 32'hA5A5A5A5, 32'hA5A5A5A5};
    cyc(0, 0, 2, 1, 5, 0, 4'h0, ent(20'h12345, 1, 0, line));
    cyc(1, 5, 0, 0, 0, 0, 4'h0, '0);
    hit_chk(20'h12345);
    chk("refill_hit", hit_o, 1);
    chk("refill_way", hit_way_o, 1);
    hit_chk(20'h12346);
    chk("refill_miss", hit_o, 0);

    cyc(0, 0, 1, 1, 5, 8, 4'b0101, ENTRY_W'(32'hAABBCCDD));
    cyc(1, 5, 0, 0, 0, 0, 4'h0, '0);
    chk("partial_word", r_data_o[ENTRY_W + 64 +: 32], 32'h11BB33DD);
    chk("partial_dirty", r_data_o[ENTRY_W + LINE_W], 1);
    chk("partial_tag", r_data_o[ENTRY_W + LINE_W + 2 +: TAG_W], 20'h12345);

    cyc(1, 9, 2, 0, 9, 0, 4'h0, ent(20'h7, 1, 0, rnd_line()));
    hit_chk(20'h7);
    chk("fwd_hit", hit_o, 1);

    for (int k = 0; k < 4; k++) cyc(0, 0, 2, k, 3, 0, 4'h0, ent(TAG_W'(k + 16), 1, 0, rnd_line()));
    cyc(1, 3, 0, 0, 0, 0, 4'h0, '0);
    chk("victim_full", victim_way_o, 0);
    cyc(0, 0, 2, 0, 3, 0, 4'h0, ent(20'h30, 1, 1, rnd_line()));
    cyc(1, 3, 0, 0, 0, 0, 4'h0, '0);
    chk("victim_ptr", victim_way_o, 1);
    cyc(0, 0, 2, 2, 3, 0, 4'h0, ent(20'h31, 0, 0, rnd_line()));
    cyc(1, 3, 0, 0, 0, 0, 4'h0, '0);
    chk("victim_invalid", victim_way_o, 2);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
          4'($urandom), ent(TAG_W'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), rnd_line()));
      hit_chk(TAG_W'($urandom_range(0, 3)));
    end

    // Reset while the table holds data, then again part-way through the sweep
    rst = 1'b1;
    #1;
    rst_chk("rst_run");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (100) idle();
    rst = 1'b1;
    #1;
    rst_chk("rst_sweep");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      cyc(1, 0, 2, 1, 0, 0, 4'h0, ent(20'h55, 1, 1, rnd_line()));
    end
    cyc(1, 0, 0, 0, 0, 0, 4'h0, '0);
    hit_chk(20'h55);
    chk("blocked_write_v", r_data_o[ENTRY_W + LINE_W + 1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_table_nway.md
# cache_table_nway

Parametrised N-way set-associative tag/data store for the L1 I/D caches. Generalises the fixed 2-way table to WAYS ways and configurable index/tag/line widths, adds a hardware valid/dirty clearing sweep after reset, a registered read port with tag compare and hit-way encoding, same-cycle write-to-read forwarding, and a per-set replacement pointer producing a victim way. Sits between the cache control FSM and the storage RAMs. The control FSM issues lookups, refills (full-line writes) and store hits (partial writes).

## Interface
- WAYS, 2, number of ways, power of two, 2..8
- INDEX_W, 8, set index width; SETS = 2^INDEX_W
- TAG_W, 20, tag width
- LINE_W, 128, line data bits; WORDS = LINE_W/32; OFFSET_W = log2(LINE_W/8)
- Derived: ENTRY_W = TAG_W+2+LINE_W; WAY_W = max(1, log2(WAYS))

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ready_o  out  1  table initialised; requests accepted only when 1
- rd_req_i  in  1  lookup request
- r_index_i  in  INDEX_W  lookup set
- cmp_tag_i  in  TAG_W  physical tag for the lookup, driven in the cycle after rd_req_i
- r_data_o  out  WAYS*ENTRY_W  way k = bits [k*ENTRY_W +: ENTRY_W], layout {tag, v, d, data}
- hit_o  out  1  some valid way's tag equals cmp_tag_i
- hit_way_o  out  WAY_W  lowest-numbered hitting way
- victim_way_o  out  WAY_W  replacement way for the last looked-up set
- w_type_i  in  2  2'b10 full write, 2'b01 partial write, 2'b00 and 2'b11 no write
- way_i  in  WAY_W  target way of the write
- w_index_i  in  INDEX_W  target set of the write
- offset_i  in  OFFSET_W  byte offset for a partial write; bits [1:0] ignored
- wstrb_i  in  4  byte enables for a partial write
- w_data_i  in  ENTRY_W  full write: {tag,v,d,data}; partial write: only [31:0] used

## Operation
- FSM states: INIT, RUN.
- Reset → INIT with sweep counter 0.
- INIT: each cycle writes v=0, d=0 to every way of set[counter], then increments the counter. Tag and data are don't-care.
  - After set SETS-1 is written, the FSM moves to RUN and ready_o goes to 1.
  - rst during INIT restarts the sweep at 0.
  - rd_req_i and w_type_i are ignored while ready_o=0.
- Full write: replaces the entry {tag,v,d,data} of (w_index_i, way_i). It also sets repl_ptr[w_index_i] = (way_i+1) mod WAYS.
- Partial write: affects word offset_i[OFFSET_W-1:2] of (w_index_i, way_i).
  - Bytes with wstrb_i=1 take w_data_i; other bytes are kept.
  - d is set to 1; tag and v are unchanged.
  - wstrb_i=0 still sets d.
- Lookup: r_data_o is loaded with all ways of r_index_i and held until the next accepted lookup.
- hit_o and hit_way_o are combinational from the held r_data_o and the live cmp_tag_i.
  - A hit requires v=1 and tag equality.
  - With multiple hits, hit_way_o is the lowest-numbered hitting way.
  - With no hit, hit_way_o=0.
- victim_way_o is registered with the lookup: the lowest-numbered invalid way of the set if any exists, else repl_ptr[set].
- Simultaneous lookup and write to the same set in the same cycle: the captured r_data_o includes the write (write-first forwarding).
  - This also applies to partial merges.
  - victim_way_o uses the post-write valid bits and pointer.
- repl_ptr is held in flops, reset asynchronously to 0.

## Timing
- Reset values: ready_o=0, r_data_o=0, hit_o=0, hit_way_o=0, victim_way_o=0, FSM=INIT, sweep counter=0.
- Init duration: ready_o rises at the clock edge that writes set SETS-1, i.e. SETS cycles after rst deasserts.
- Lookup latency: rd_req_i sampled at edge T; r_data_o and victim_way_o are valid after edge T, for the whole of cycle T+1 and beyond.
- hit_o has zero latency from cmp_tag_i.
- Write latency: the write commits at edge T and is visible to a lookup sampled at edge T or later.
- Throughput: one lookup plus one write per cycle, with no stalls in RUN.

## Test plan
- Init sweep: WAYS=2, INDEX_W=8. Release rst → ready_o=0 for 256 cycles then 1. A lookup of any set then gives v=0 in all ways, hit_o=0, victim_way_o=0.
- Refill and hit: full write set 5, way 1, tag 0x12345, v=1, d=0, data 0xA5.., then lookup set 5 with cmp_tag_i=0x12345 → hit_o=1, hit_way_o=1. The same lookup with cmp_tag_i=0x12346 → hit_o=0.
- Partial write: word 2 of set 5 way 1 is 0x11223344; write offset 0x8, wstrb 4'b0101, data 0xAABBCCDD → word 2 reads 0x11BB33DD, d=1, tag unchanged.
- Forwarding: in one cycle, full write to set 9 way 0 (tag 0x7, v=1) and lookup set 9 → next cycle shows way 0 tag 0x7 v=1, and cmp_tag_i=0x7 gives hit_o=1.
- Victim: WAYS=4. Fill ways 0-3 of set 3 in that order, then lookup set 3 → victim_way_o=0. A further full write to way 0 followed by a lookup → victim_way_o=1. With way 2 cleared to v=0 → victim_way_o=2.
- Reset mid-sweep: assert rst at sweep count 100 → outputs return to reset values. After release, ready_o stays 0 for another full 256 cycles, and writes attempted meanwhile have no effect.
